// File: rtl/alu_logic_seq.sv
// ---------------------------------------------------------------------------
// alu_logic_seq
//   Bit-serial logic unit for the ALU datapath. An operand pair and opcode
//   are taken on a valid/ready input port, the result is built one bit per
//   clock (LSB first), then presented with a zero flag on a valid/ready
//   output port. The input and output handshakes never overlap.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operand/opcode present
//   in_ready   out  1      unit can accept (IDLE only)
//   op         in   2      00=AND 01=OR 10=XOR 11=NAND
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result available (DONE only)
//   out_ready  in   1      consumer takes the result
//   y          out  WIDTH  registered result
//   zero       out  1      y == 0, meaningful while out_valid=1
//   busy       out  1      high in SHIFT or DONE
// ---------------------------------------------------------------------------
module alu_logic_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;

    logic [WIDTH-1:0] w_fbit;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_last;

    function automatic logic f_bit(input logic ai, input logic bi, input logic [1:0] opc);
        logic res;
        case (opc)
            2'b00:   res = ai & bi;
            2'b01:   res = ai | bi;
            2'b10:   res = ai ^ bi;
            default: res = ~(ai & bi);
        endcase
        return res;
    endfunction

    // Each bit position has its own function cell; only the position equal
    // to the counter is written into the shift register on a SHIFT edge.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_fbit[gi]       = f_bit(r_a[gi], r_b[gi], r_op);
            assign w_shift_next[gi] = (r_cnt == CW'(gi)) ? w_fbit[gi] : r_shift[gi];
        end
    endgenerate

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_y     <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + CW'(1);
                    // y/zero only change on the final bit, so a partial
                    // result is never visible on the outputs.
                    if (w_last) begin
                        r_y    <= w_shift_next;
                        r_zero <= (w_shift_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign y         = r_y;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_logic_seq.sv
module tb_alu_logic_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] prev_y;

    alu_logic_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Whole-word reference of the logic operation.
    function automatic logic [W-1:0] ref_fn(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic [1:0] rop);
        case (rop)
            2'd0:    return ra & rb;
            2'd1:    return ra | rb;
            2'd2:    return ra ^ rb;
            default: return ~(ra & rb);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, WIDTH shift edges, optional backpressure
    // in DONE, release. With inject=1 new operands are offered while busy.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [1:0] top, input int hold, input bit inject);
        logic [W-1:0] exp;
        exp = ref_fn(ta, tb_, top);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_;
        op       = top;
        in_valid = 1'b1;
        tick();                                   // accept edge T
        in_valid = inject;
        a        = W'($urandom);
        b        = W'($urandom);
        op       = 2'($urandom);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_in_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k < W; k++) begin
            tick();                               // edges T+1 .. T+W-1
            chk("shift_out_valid", 32'(out_valid), 32'd0);
            chk("shift_y_hidden", 32'(y), 32'(prev_y));
        end
        tick();                                   // edge T+W
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_y", 32'(y), 32'(exp));
        chk("done_zero", 32'(zero), 32'(exp == '0));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            a         = W'($urandom);
            b         = W'($urandom);
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_y", 32'(y), 32'(exp));
            chk("hold_zero", 32'(zero), 32'(exp == '0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();                                   // release edge
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_y_kept", 32'(y), 32'(exp));
        prev_y = exp;
        $display("txn op=%0d a=0x%02h b=0x%02h hold=%0d inject=%0d y=0x%02h exp=0x%02h zero=%0d",
                 top, ta, tb_, hold, inject, y, exp, zero);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'd0;
        a         = '0;
        b         = '0;
        prev_y    = '0;

        // Reset held for two edges
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        $display("txn reset in_ready=%0d out_valid=%0d busy=%0d y=0x%02h", in_ready, out_valid, busy, y);
        rst_n = 1'b1;
        tick();

        // Directed operations
        run_op(8'hF0, 8'h3C, 2'd0, 0, 1'b0);
        run_op(8'hA5, 8'h0F, 2'd1, 0, 1'b0);
        run_op(8'hA5, 8'hFF, 2'd2, 1, 1'b0);
        run_op(8'hFF, 8'hFF, 2'd3, 0, 1'b0);
        run_op(8'h0F, 8'hF0, 2'd0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 2'd0, 0, 1'b0);

        // Backpressure for 5 cycles with new operands offered while busy
        run_op(8'h3C, 8'hC3, 2'd2, 5, 1'b1);

        // Reset in the middle of SHIFT
        a        = 8'h55;
        b        = 8'hAA;
        op       = 2'd2;
        in_valid = 1'b1;
        tick();                                   // accept
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();                                   // 4th SHIFT edge, reset
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd0);
        for (int k = 0; k < W + 4; k++) begin
            tick();
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        $display("txn midop_reset y=0x%02h out_valid=%0d", y, out_valid);
        prev_y = '0;
        run_op(8'hFF, 8'h81, 2'd0, 0, 1'b0);

        // Randomized operations against the reference
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
